frame_cell_buffer: RTL and testbench
====================================

// Module: frame_cell_buffer
// PURPOSE
//  - Single-clock, dual-port (1 write, 1 read) frame buffer for one 640x480 frame of 3-bit pixels.
//  - Addressed by (x, y) pixel coordinates on both ports.
//  - Sits between the renderer (write side) and the VGA scan-out (read side) of the framebuffer.
//  - Infers block RAM; the read port is registered.
// PARAMETERS
//  - FRAME_WIDTH   640  pixels per row
//  - FRAME_HEIGHT  480  rows per frame
//  - PIXEL_BITS    3    bits per pixel
//  - X_BITS        10   x coordinate width
//  - Y_BITS        9    y coordinate width
//  - DEPTH         FRAME_WIDTH*FRAME_HEIGHT (307200), derived, not overridable
// PORTS
//  - clk                 in   1           single clock, rising edge
//  - rst                 in   1           synchronous, active-high reset
//  - write_frame_width   in   X_BITS      write x coordinate (column)
//  - write_frame_height  in   Y_BITS      write y coordinate (row)
//  - write_enable        in   1           write strobe
//  - write_data          in   PIXEL_BITS  pixel to store
//  - read_frame_width    in   X_BITS      read x coordinate
//  - read_frame_height   in   Y_BITS      read y coordinate
//  - read_data           out  PIXEL_BITS  registered pixel at the read address
// BEHAVIOUR
//  - Linear address = y*FRAME_WIDTH + x, computed as 19-bit unsigned.
//  - Write: on posedge clk with write_enable=1, mem[waddr] <= write_data; write_enable=0 leaves memory untouched.
//  - Read: on posedge clk, read_data <= mem[raddr]; latency 1 cycle.
//    - Address presented before edge N gives valid data after edge N, held until edge N+1.
//  - Read port is independent of write_enable; a read occurs every cycle.
//  - Read-during-write at the same address in the same cycle: read_data returns the OLD contents (read-first).
//    - The new value is visible from the next cycle's read onward.
//  - Back-to-back writes to consecutive addresses, one per cycle, are supported with no stall.
//  - Reset (rst=1 at posedge): read_data <= 0; writes in that cycle are suppressed.
//    - Memory contents are NOT cleared by reset (no clear sequencer).
//    - Reset mid-stream affects only the output register; stored pixels survive.
//  - Memory power-up contents are 0 (initialised), so a read before any write returns 0.
//  - No handshake; ports are always ready.
// CONFIGURATION
//  - FRAME_CELL_BOUNDS_CHECK_EN defined:
//    - A write with x>=FRAME_WIDTH or y>=FRAME_HEIGHT is dropped.
//    - A read with x>=FRAME_WIDTH or y>=FRAME_HEIGHT returns read_data=0 next cycle.
//  - FRAME_CELL_BOUNDS_CHECK_EN undefined:
//    - No per-coordinate check; out-of-range x aliases into later rows via the linear address.
//    - A linear address >= DEPTH is dropped on write and reads as 0.
// TESTING
//  - Fill: write every (x,y) in raster order with data=(index+1) mod 8, read addr = write addr each cycle;
//    -> read_data each cycle equals the previous contents (0 on first pass).
//  - Readback: write_enable=0, raster scan all 307200 addresses
//    -> read_data one cycle later equals (index+1) mod 8 for every pixel, zero mismatches.
//  - Read-during-write: (5,7) holds 3; write 6 to (5,7) with read at (5,7) -> read_data=3, next cycle 6.
//  - Reset: after fill, rst=1 for 1 cycle with write_enable=1, data=0 at (0,0)
//    -> read_data=0; then read (0,0) -> 1 (write suppressed, memory kept).
//  - Corners: write 7 to (639,479), 2 to (0,479), 5 to (639,0) -> each reads back exactly, neighbours unchanged.
//  - Bounds (macro on): write 4 at (640,0) -> (0,1) unchanged, read (640,0) -> 0;
//    macro off: same write -> (0,1) reads 4.

Source files
------------

// File: rtl/frame_cell_buffer.sv
// Frame buffer for one 640x480 frame of 3-bit pixels, 1 write + 1 read port, addressed by (x, y).
// Latency: read_data is registered, valid one clk after the read address; read-first on same-address collision.
// Backpressure: none, both ports accept every cycle; optional macro FRAME_CELL_BOUNDS_CHECK_EN adds per-coordinate range checks.
module frame_cell_buffer #(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int PIXEL_BITS   = 3,
    parameter int X_BITS       = 10,
    parameter int Y_BITS       = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [X_BITS-1:0]     write_frame_width,
    input  logic [Y_BITS-1:0]     write_frame_height,
    input  logic                  write_enable,
    input  logic [PIXEL_BITS-1:0] write_data,
    input  logic [X_BITS-1:0]     read_frame_width,
    input  logic [Y_BITS-1:0]     read_frame_height,
    output logic [PIXEL_BITS-1:0] read_data
);

    localparam int DEPTH     = FRAME_WIDTH * FRAME_HEIGHT;
    localparam int ADDR_BITS = 19;

    // Zero power-up contents so reads before any write return 0; reset never clears it.
    logic [PIXEL_BITS-1:0] mem [DEPTH] = '{default: '0};

    logic [ADDR_BITS-1:0] waddr;
    logic [ADDR_BITS-1:0] raddr;
    logic                 wr_ok;
    logic                 rd_ok;

    // Raster linear address y*W + x; worst case 511*640+1023 still fits 19 bits.
    assign waddr = ADDR_BITS'(write_frame_height) * ADDR_BITS'(FRAME_WIDTH) + ADDR_BITS'(write_frame_width);
    assign raddr = ADDR_BITS'(read_frame_height) * ADDR_BITS'(FRAME_WIDTH) + ADDR_BITS'(read_frame_width);

`ifdef FRAME_CELL_BOUNDS_CHECK_EN
    // Each coordinate must be inside the frame; this also keeps the linear address below DEPTH.
    assign wr_ok = (32'(write_frame_width) < FRAME_WIDTH) && (32'(write_frame_height) < FRAME_HEIGHT);
    assign rd_ok = (32'(read_frame_width) < FRAME_WIDTH) && (32'(read_frame_height) < FRAME_HEIGHT);
`else
    // Only the linear address is guarded; an oversize x simply wraps into a later row.
    assign wr_ok = 32'(waddr) < DEPTH;
    assign rd_ok = 32'(raddr) < DEPTH;
`endif

    // Write port: store the pixel when strobed, in range and not in reset.
    always_ff @(posedge clk) begin
        if (!rst && write_enable && wr_ok) begin
            mem[waddr] <= write_data;
        end
    end

    // Read port: registered read every cycle, sees pre-write contents on a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_data <= '0;
        end else if (rd_ok) begin
            read_data <= mem[raddr];
        end else begin
            read_data <= '0;
        end
    end

endmodule

// File: tb/tb_frame_cell_buffer.sv
// Scoreboard bench for frame_cell_buffer: stimulus pushes expected read_data, a monitor pops and compares.
// Each driven cycle yields one expectation checked on the following falling edge.
// The DUT has no backpressure, so one expectation is queued per cycle.
module tb_frame_cell_buffer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] write_frame_width = '0;
    logic [8:0] write_frame_height = '0;
    logic       write_enable = 1'b0;
    logic [2:0] write_data = '0;
    logic [9:0] read_frame_width = '0;
    logic [8:0] read_frame_height = '0;
    logic [2:0] read_data;

    int    compared   = 0;
    int    mismatched = 0;
    int    exp_q[$];
    string name_q[$];
    int    mon_e;
    string mon_n;

    localparam int FILL_N = 1280;

    frame_cell_buffer dut (
        .clk               (clk),
        .rst               (rst),
        .write_frame_width (write_frame_width),
        .write_frame_height(write_frame_height),
        .write_enable      (write_enable),
        .write_data        (write_data),
        .read_frame_width  (read_frame_width),
        .read_frame_height (read_frame_height),
        .read_data         (read_data)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs just after a falling edge and queue what read_data must be
    // after the next rising edge (exp < 0 means no check for that cycle).
    task automatic drive(input logic r, input logic we, input int wx, input int wy, input int wd,
                         input int rx, input int ry, input string name, input int exp);
        @(negedge clk);
        #1;
        rst                = r;
        write_enable       = we;
        write_frame_width  = 10'(wx);
        write_frame_height = 9'(wy);
        write_data         = 3'(wd);
        read_frame_width   = 10'(rx);
        read_frame_height  = 9'(ry);
        exp_q.push_back(exp);
        name_q.push_back(name);
    endtask

    task automatic rd(input int rx, input int ry, input string name, input int exp);
        drive(1'b0, 1'b0, 0, 0, 0, rx, ry, name, exp);
    endtask

    // Monitor: one output per cycle, compared against the oldest queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            if (mon_e >= 0) begin
                compared++;
                if (read_data !== 3'(mon_e)) begin
                    mismatched++;
                    $display("FAIL %s: read_data=%0d expected %0d", mon_n, read_data, mon_e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state: output register held at 0.
        drive(1'b1, 1'b0, 0, 0, 0, 0, 0, "reset0", 0);
        drive(1'b1, 1'b0, 0, 0, 0, 0, 0, "reset1", 0);

        // Fill the first two rows; read-first at the same address gives the old (zero) value.
        for (int i = 0; i < FILL_N; i++)
            drive(1'b0, 1'b1, i % 640, i / 640, (i + 1) % 8, i % 640, i / 640, "fill", 0);

        // Readback of the filled region.
        for (int i = 0; i < FILL_N; i++)
            rd(i % 640, i / 640, "readback", (i + 1) % 8);

        // Read-during-write at (5,7).
        drive(1'b0, 1'b1, 5, 7, 3, 0, 0, "rdw_setup", 1);
        drive(1'b0, 1'b1, 5, 7, 6, 5, 7, "rdw_old", 3);
        rd(5, 7, "rdw_new", 6);

        // Reset with a write pending: output cleared, write suppressed, memory kept.
        drive(1'b1, 1'b1, 0, 0, 0, 5, 7, "rst_out", 0);
        rd(0, 0, "rst_wr_suppressed", 1);
        rd(5, 7, "rst_mem_kept", 6);

        // Corners.
        drive(1'b0, 1'b1, 639, 479, 7, 639, 479, "c_br_pre", 0);
        drive(1'b0, 1'b1, 0, 479, 2, 0, 479, "c_bl_pre", 0);
        drive(1'b0, 1'b1, 639, 0, 5, 639, 0, "c_tr_pre", 0);
        rd(639, 479, "c_br", 7);
        rd(0, 479, "c_bl", 2);
        rd(639, 0, "c_tr", 5);
        rd(638, 479, "c_br_left", 0);
        rd(639, 478, "c_br_up", 0);
        rd(1, 479, "c_bl_right", 0);
        rd(638, 0, "c_tr_left", 7);
        rd(0, 1, "c_tr_next", 1);

`ifdef FRAME_CELL_BOUNDS_CHECK_EN
        // Out-of-range x is dropped on write and reads as 0.
        drive(1'b0, 1'b1, 640, 0, 4, 640, 0, "oob_same", 0);
        rd(0, 1, "oob_alias", 1);
        rd(640, 0, "oob_read", 0);
        rd(0, 480, "oob_y_read", 0);
`else
        // Out-of-range x wraps to (0,1); the same-cycle read sees its old contents.
        drive(1'b0, 1'b1, 640, 0, 4, 640, 0, "oob_same", 1);
        rd(0, 1, "oob_alias", 4);
        rd(640, 0, "oob_read", 4);
        rd(0, 480, "oob_y_read", 0);
`endif
        // Linear address beyond the frame: dropped on write, reads 0 in both builds.
        drive(1'b0, 1'b1, 1023, 511, 5, 1023, 511, "far_same", 0);
        rd(1023, 511, "far_read", 0);
        rd(639, 479, "far_last_kept", 7);

        // Let the monitor drain, bounded.
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
